spi_alu: RTL and testbench

SPI_ALU -- requirements
Module: spi_alu

---
 rtl/spi_alu_if.sv | 13 +
 rtl/spi_alu.sv | 112 +++++++++++
 tb/tb_spi_alu.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/spi_alu_if.sv
// spi_alu_if: shared SPI bus carrying slave selects, mosi and a tri-stated miso
// Ports (SlaveSpi modport):
//   nss  - active-low slave selects, one per slave on the bus
//   mosi - master-to-slave serial data
//   miso - slave-to-master serial data, released to Z by unselected slaves
interface Spi #(
    parameter int NssCount = 1
);
    logic [NssCount-1:0] nss;
    logic mosi;
    tri miso;
    modport SlaveSpi(input nss, input mosi, output miso);
endinterface

// File: rtl/spi_alu.sv
// spi_alu: SPI slave that receives an opcode and two operands, computes one ALU operation and shifts back result plus flags
// Ports:
//   i_clock - system clock, all sampling on the rising edge
//   i_reset - synchronous active-high reset
//   spi     - SPI slave port; nss[NssPosition] low selects this block
//   o_busy  - high whenever a frame is in progress (state is not RECEIVE)
//   o_abort - one-cycle pulse when a frame is cut short by deselection
module spi_alu #(
    parameter int RegWidth = 8,
    parameter int NssCount = 1,
    parameter int NssPosition = 0
) (
    input  logic i_clock,
    input  logic i_reset,
    Spi.SlaveSpi spi,
    output logic o_busy,
    output logic o_abort
);
    localparam int InBits = 3 + 2 * RegWidth;
    localparam int OutBits = RegWidth + 5;
    localparam int InCw = $clog2(InBits);
    localparam int OutCw = $clog2(OutBits);
    localparam int ShW = $clog2(RegWidth);
    localparam int Msb = RegWidth - 1;

    if (NssPosition >= NssCount || RegWidth < 4 || RegWidth > 32) begin : g_bad_params
        $error("spi_alu: illegal parameter set");
    end

    typedef enum logic [2:0] {RECEIVE, RECEIVING, OPERATE, SEND, SENDING} state_t;

    state_t state, state_next;
    logic [InCw-1:0] counter_in;
    logic [OutCw-1:0] counter_out;
    logic [InBits-1:0] packet_in;
    logic [OutBits-1:0] packet_out;
    logic active, abort, last_in, last_out, miso_bit;
    logic [2:0] op;
    logic [RegWidth-1:0] op_1, op_2, result;
    logic [RegWidth:0] sum, diff;
    logic [ShW-1:0] shamt;
    logic z, n, c, v, e;

    assign active = !spi.nss[NssPosition];
    assign last_in = counter_in == InCw'(InBits - 1);
    assign last_out = counter_out == OutCw'(OutBits - 1);

    assign op = packet_in[2:0];
    assign op_1 = packet_in[3 +: RegWidth];
    assign op_2 = packet_in[3 + RegWidth +: RegWidth];
    assign shamt = op_2[ShW-1:0];
    // One extra bit holds carry for ADD and borrow (op_1 < op_2) for SUB
    assign sum = {1'b0, op_1} + {1'b0, op_2};
    assign diff = {1'b0, op_1} - {1'b0, op_2};

    assign result = op == 3'd0 ? sum[Msb:0] :
                    op == 3'd1 ? diff[Msb:0] :
                    op == 3'd2 ? op_1 & op_2 :
                    op == 3'd3 ? op_1 | op_2 :
                    op == 3'd4 ? op_1 ^ op_2 :
                    op == 3'd5 ? op_1 << shamt :
                    op == 3'd6 ? op_1 >> shamt : '0;
    assign e = op == 3'd7;
    // Invalid opcode reports a zero result without raising Z
    assign z = !e && result == '0;
    assign n = result[Msb];
    assign c = op == 3'd0 ? sum[RegWidth] : op == 3'd1 ? diff[RegWidth] : 1'b0;
    assign v = op == 3'd0 ? (op_1[Msb] == op_2[Msb]) && (result[Msb] != op_1[Msb]) :
               op == 3'd1 ? (op_1[Msb] != op_2[Msb]) && (result[Msb] != op_1[Msb]) : 1'b0;

    // Deselection wins over the last-bit transition, so an abort never reaches OPERATE
    always_comb begin
        state_next = RECEIVE;
        abort = 1'b0;
        case (state)
            RECEIVE:   state_next = active && spi.mosi ? RECEIVING : RECEIVE;
            RECEIVING: begin
                abort = !active;
                state_next = !active ? RECEIVE : last_in ? OPERATE : RECEIVING;
            end
            OPERATE:   state_next = SEND;
            SEND:      state_next = active && !spi.mosi ? SENDING : SEND;
            SENDING:   begin
                abort = !active;
                state_next = !active || last_out ? RECEIVE : SENDING;
            end
            default:   state_next = RECEIVE;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state <= RECEIVE;
            counter_in <= '0;
            counter_out <= '0;
            packet_in <= '0;
            packet_out <= '0;
            o_abort <= 1'b0;
        end else begin
            state <= state_next;
            o_abort <= abort;
            counter_in <= state == RECEIVING && active && !last_in ? counter_in + 1'b1 : '0;
            counter_out <= state == SENDING && active && !last_out ? counter_out + 1'b1 : '0;
            if (state == RECEIVING && active) packet_in[counter_in] <= spi.mosi;
            if (state == OPERATE) packet_out <= {e, v, c, n, z, result};
        end
    end

    assign miso_bit = state == SEND ? 1'b1 : state == SENDING ? packet_out[counter_out] : 1'b0;
    assign spi.miso = active ? miso_bit : 1'bz;
    assign o_busy = state != RECEIVE;
endmodule

// File: tb/tb_spi_alu.sv
// tb_spi_alu: scoreboard bench for spi_alu with RegWidth=8, NssCount=2, NssPosition=1
module tb_spi_alu;
    logic clk = 1'b0;
    logic rst, busy, abort_o, tb_en, tb_val;
    int total, passed;
    logic [12:0] q[$];

    always #5 clk = ~clk;

    Spi #(.NssCount(2)) bus();
    assign bus.miso = tb_en ? tb_val : 1'bz;

    spi_alu #(.RegWidth(8), .NssCount(2), .NssPosition(1)) dut (
        .i_clock(clk),
        .i_reset(rst),
        .spi(bus.SlaveSpi),
        .o_busy(busy),
        .o_abort(abort_o)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Z is proven by overpowering the undriven line both ways from the bench
    task automatic check_z(input string name);
        tb_en = 1'b1;
        tb_val = 1'b1;
        #1;
        chk({name, " z-hi"}, bus.miso, 1);
        tb_val = 1'b0;
        #1;
        chk({name, " z-lo"}, bus.miso, 0);
        tb_en = 1'b0;
    endtask

    task automatic send_req(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [18:0] f;
        f = {b, a, op};
        bus.nss = 2'b01;
        bus.mosi = 1'b1;
        tick();
        for (int i = 0; i < 19; i++) begin
            bus.mosi = f[i];
            tick();
        end
    endtask

    task automatic read_resp();
        bus.mosi = 1'b0;
        repeat (14) tick();
    endtask

    task automatic frame(input string name, input logic [2:0] op, input logic [7:0] a,
                         input logic [7:0] b, input logic [12:0] exp);
        q.push_back(exp);
        send_req(op, a, b);
        bus.mosi = 1'b1;
        tick();
        chk({name, " send-miso"}, bus.miso, 1);
        chk({name, " send-busy"}, busy, 1);
        read_resp();
        chk({name, " idle-busy"}, busy, 0);
    endtask

    // Monitor: a selected SEND (miso=1) with mosi=0 starts a 13-bit response
    initial begin : monitor
        logic [12:0] got;
        logic [12:0] exp;
        bit ok;
        forever begin
            @(negedge clk);
            if (!rst && !bus.nss[1] && bus.miso === 1'b1 && !bus.mosi) begin
                ok = 1'b1;
                for (int k = 0; k < 13; k++) begin
                    @(negedge clk);
                    if (rst || bus.nss[1]) ok = 1'b0;
                    got[k] = bus.miso;
                end
                if (ok) begin
                    if (q.size() == 0) chk("unexpected response", {19'd0, got}, 32'hFFFF_FFFF);
                    else begin
                        exp = q.pop_front();
                        chk("response", {19'd0, got}, {19'd0, exp});
                    end
                end
            end
        end
    end

    initial begin
        logic [18:0] f;
        total = 0;
        passed = 0;
        rst = 1'b1;
        bus.nss = 2'b01;
        bus.mosi = 1'b0;
        tb_en = 1'b0;
        tb_val = 1'b0;
        repeat (2) tick();
        chk("reset busy", busy, 0);
        chk("reset abort", abort_o, 0);
        chk("reset miso", bus.miso, 0);
        rst = 1'b0;
        bus.nss = 2'b11;
        tick();
        check_z("idle desel");
        for (int i = 0; i < 4; i++) begin
            bus.mosi = ~bus.mosi;
            tick();
        end
        chk("desel receive busy", busy, 0);

        frame("add 7f+01", 3'd0, 8'h7F, 8'h01, 13'h0A80);
        frame("add ff+01", 3'd0, 8'hFF, 8'h01, 13'h0500);
        frame("sub 03-05", 3'd1, 8'h03, 8'h05, 13'h06FE);
        frame("sub 80-01", 3'd1, 8'h80, 8'h01, 13'h087F);
        frame("and", 3'd2, 8'hF0, 8'h0F, 13'h0100);
        frame("or", 3'd3, 8'hA0, 8'h05, 13'h02A5);
        frame("shr", 3'd6, 8'h80, 8'h0B, 13'h0010);
        frame("op7", 3'd7, 8'h12, 8'h34, 13'h1000);
        frame("add 2+3", 3'd0, 8'h02, 8'h03, 13'h0005);

        // Deselect after 5 request bits
        f = {8'h3C, 8'hF0, 3'd4};
        bus.nss = 2'b01;
        bus.mosi = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) begin
            bus.mosi = f[i];
            tick();
        end
        bus.nss = 2'b11;
        chk("abort pre busy", busy, 1);
        chk("abort pre pulse", abort_o, 0);
        tick();
        chk("abort pulse", abort_o, 1);
        chk("abort busy", busy, 0);
        tick();
        chk("abort one-shot", abort_o, 0);
        bus.mosi = 1'b0;
        frame("xor", 3'd4, 8'hF0, 8'h3C, 13'h02CC);

        // Deselect coincident with the last request bit
        bus.nss = 2'b01;
        bus.mosi = 1'b1;
        tick();
        for (int i = 0; i < 18; i++) begin
            bus.mosi = f[i];
            tick();
        end
        bus.mosi = f[18];
        bus.nss = 2'b11;
        tick();
        chk("last-bit abort pulse", abort_o, 1);
        chk("last-bit abort busy", busy, 0);
        tick();
        chk("last-bit abort one-shot", abort_o, 0);
        bus.mosi = 1'b0;

        // Deselect through OPERATE and SEND; result must be held
        q.push_back(13'h0030);
        send_req(3'd0, 8'h10, 8'h20);
        bus.nss = 2'b11;
        check_z("operate desel");
        tick();
        check_z("send desel");
        for (int i = 0; i < 4; i++) begin
            bus.mosi = ~bus.mosi;
            tick();
        end
        chk("send desel busy", busy, 1);
        chk("send desel abort", abort_o, 0);
        bus.nss = 2'b01;
        bus.mosi = 1'b1;
        tick();
        chk("send held miso", bus.miso, 1);
        read_resp();
        chk("held idle busy", busy, 0);

        // Reset while SENDING bit 4
        send_req(3'd0, 8'h02, 8'h03);
        bus.mosi = 1'b1;
        tick();
        bus.mosi = 1'b0;
        repeat (5) tick();
        rst = 1'b1;
        tick();
        chk("mid-send reset busy", busy, 0);
        chk("mid-send reset miso", bus.miso, 0);
        chk("mid-send reset abort", abort_o, 0);
        rst = 1'b0;
        tick();
        frame("shl", 3'd5, 8'h01, 8'h03, 13'h0008);

        for (int i = 0; i < 20 && q.size() != 0; i++) tick();
        chk("queue drained", q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
